// File: rtl/traffic_scheduler_pkg.sv
// rtl/traffic_scheduler_pkg.sv - shared grid constants, car bus widths and sequencer state encoding
package traffic_scheduler_pkg;

    localparam int GRID_COLS     = 20;
    localparam int GRID_ROWS     = 15;
    localparam int NUM_LANES     = 4;
    localparam int CARS_PER_LANE = 4;
    localparam int NUM_CARS      = NUM_LANES * CARS_PER_LANE;
    localparam int COL_W         = 5;
    localparam int ROW_W         = 4;
    localparam int BASE_ROW      = 7;
    localparam int CAR_X_W       = NUM_CARS * COL_W;
    localparam int CAR_Y_W       = NUM_CARS * ROW_W;
    localparam int LANE_X_W      = CARS_PER_LANE * COL_W;

    // Frames per one-column move at level 0, lane l at [4l+3:4l].
    localparam logic [15:0] LANE_PERIODS = {4'd4, 4'd5, 4'd6, 4'd8};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic [COL_W-1:0] reset_col(input int lane, input int k);
        int v;
        v = 2 * lane + 5 * k;
        while (v >= GRID_COLS) v = v - GRID_COLS;
        return COL_W'(v);
    endfunction

    function automatic logic [COL_W-1:0] step_col(input logic [COL_W-1:0] col, input logic move_left);
        logic [COL_W-1:0] r;
        if (move_left) r = (col == '0) ? COL_W'(GRID_COLS - 1) : col - 1'b1;
        else           r = (col == COL_W'(GRID_COLS - 1)) ? '0 : col + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/traffic_scheduler_if.sv
// rtl/traffic_scheduler_if.sv - frame tick, frog position and car bus between game logic and scheduler
interface traffic_scheduler_if import traffic_scheduler_pkg::*; ;

    logic                 frame_tick;
    logic [1:0]           level;
    logic                 pause;
    logic [COL_W-1:0]     frog_col;
    logic [ROW_W-1:0]     frog_row;
    logic [CAR_X_W-1:0]   car_x;
    logic [CAR_Y_W-1:0]   car_y;
    logic                 busy;
    logic                 done;
    logic                 hit;
    logic                 overrun;

    modport master (
        output frame_tick, level, pause, frog_col, frog_row,
        input  car_x, car_y, busy, done, hit, overrun
    );

    modport slave (
        input  frame_tick, level, pause, frog_col, frog_row,
        output car_x, car_y, busy, done, hit, overrun
    );

endinterface

// File: rtl/traffic_scheduler_lane.sv
// rtl/traffic_scheduler_lane.sv - one lane of cars: frame counter plus column registers with wrap
module traffic_scheduler_lane import traffic_scheduler_pkg::*; #(
    parameter int         LANE      = 0,
    parameter logic [3:0] PERIOD    = 4'd8,
    parameter bit         MOVE_LEFT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic [1:0]          level,
    output logic [LANE_X_W-1:0] cols
);

    logic [3:0] cnt;
    logic [3:0] shifted;
    logic [3:0] eff;
    logic       wrap;

    assign shifted = PERIOD >> level;
    assign eff     = (shifted == 4'd0) ? 4'd1 : shifted;
    // Widened compare so cnt+1 cannot overflow before reaching eff.
    assign wrap    = ({1'b0, cnt} + 5'd1) >= {1'b0, eff};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int k = 0; k < CARS_PER_LANE; k++)
                cols[k*COL_W +: COL_W] <= reset_col(LANE, k);
        end else if (step) begin
            if (wrap) begin
                cnt <= '0;
                for (int k = 0; k < CARS_PER_LANE; k++)
                    cols[k*COL_W +: COL_W] <= step_col(cols[k*COL_W +: COL_W], MOVE_LEFT);
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - per-frame lane sweep sequencer with frog/car collision check
module traffic_scheduler import traffic_scheduler_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    traffic_scheduler_if.slave  bus
);

    state_t               state, state_nx;
    logic [1:0]           lane_idx, lane_idx_nx;
    logic [1:0]           level_q, level_nx;
    logic                 pause_q, pause_nx;
    logic                 busy_q, done_q, hit_q, overrun_q;
    logic                 done_nx, hit_nx, overrun_nx;
    logic                 accept;
    logic                 any_hit;
    logic [NUM_LANES-1:0] lane_step;
    logic [CAR_X_W-1:0]   car_x_w;
    logic [CAR_Y_W-1:0]   car_y_w;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign lane_step[l] = (state == ST_SWEEP) && (lane_idx == 2'(l)) && !pause_q;

        traffic_scheduler_lane #(
            .LANE      (l),
            .PERIOD    (LANE_PERIODS[4*l +: 4]),
            .MOVE_LEFT (bit'(l % 2))
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .step  (lane_step[l]),
            .level (level_q),
            .cols  (car_x_w[l*LANE_X_W +: LANE_X_W])
        );

        for (genvar k = 0; k < CARS_PER_LANE; k++) begin : g_row
            assign car_y_w[(l*CARS_PER_LANE + k)*ROW_W +: ROW_W] = ROW_W'(BASE_ROW + l);
        end
    end

    always_comb begin
        any_hit = 1'b0;
        for (int i = 0; i < NUM_CARS; i++)
            if (car_x_w[i*COL_W +: COL_W] == bus.frog_col && car_y_w[i*ROW_W +: ROW_W] == bus.frog_row)
                any_hit = 1'b1;
    end

    always_comb begin
        state_nx    = state;
        lane_idx_nx = lane_idx;
        level_nx    = level_q;
        pause_nx    = pause_q;
        done_nx     = 1'b0;
        hit_nx      = 1'b0;
        overrun_nx  = 1'b0;
        accept      = 1'b0;

        case (state)
            ST_IDLE: begin
                accept = bus.frame_tick;
            end
            ST_SWEEP: begin
                overrun_nx  = bus.frame_tick;
                lane_idx_nx = lane_idx + 2'd1;
                if (lane_idx == 2'(NUM_LANES - 1))
                    state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                done_nx  = 1'b1;
                hit_nx   = any_hit;
                state_nx = ST_IDLE;
                // Already IDLE-bound here, so a tick this cycle starts the next sweep gap-free.
                accept   = bus.frame_tick;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (accept) begin
            level_nx    = bus.level;
            pause_nx    = bus.pause;
            lane_idx_nx = 2'd0;
            state_nx    = ST_SWEEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lane_idx  <= 2'd0;
            level_q   <= 2'd0;
            pause_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nx;
            lane_idx  <= lane_idx_nx;
            level_q   <= level_nx;
            pause_q   <= pause_nx;
            busy_q    <= (state_nx != ST_IDLE);
            done_q    <= done_nx;
            hit_q     <= hit_nx;
            overrun_q <= overrun_nx;
        end
    end

    assign bus.car_x   = car_x_w;
    assign bus.car_y   = car_y_w;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hit     = hit_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - directed-vector bench for traffic_scheduler
module tb_traffic_scheduler;
    import traffic_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_scheduler_if bus ();

    traffic_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] cx(input int i);
        return bus.car_x[5*i +: 5];
    endfunction

    function automatic logic [3:0] cy(input int i);
        return bus.car_y[4*i +: 4];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns done latency in edges after E0 (-1 if never) and hit at done.
    task automatic run_frame(output logic h, output int lat);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        lat = -1;
        h   = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                h   = bus.hit;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic h;
        int   lat;
        int   hits;
        int   dn;

        bus.frame_tick = 1'b0;
        bus.level      = 2'd0;
        bus.pause      = 1'b0;
        bus.frog_col   = 5'd31;
        bus.frog_row   = 4'd15;
        @(negedge clk);
        do_reset();

        chk("rst_car0_x", cx(0), 0);
        chk("rst_car1_x", cx(1), 5);
        chk("rst_car2_x", cx(2), 10);
        chk("rst_car3_x", cx(3), 15);
        chk("rst_car0_y", cy(0), 7);
        chk("rst_car4_x", cx(4), 2);
        chk("rst_car4_y", cy(4), 8);
        chk("rst_car15_x", cx(15), 1);
        chk("rst_car15_y", cy(15), 10);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_overrun", bus.overrun, 0);

        // Level 0: lane0 period 8, lane1 6, lane2 5, lane3 4.
        for (int t = 1; t <= 7; t++) begin
            run_frame(h, lat);
            if (t == 1) chk("l0_latency", lat, 5);
        end
        chk("l0_7_car0", cx(0), 0);
        chk("l0_7_car4", cx(4), 1);
        chk("l0_7_car8", cx(8), 5);
        chk("l0_7_car12", cx(12), 5);

        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("t8_busy_e0", bus.busy, 1);
        chk("t8_car0_e0", cx(0), 0);
        @(negedge clk);
        chk("t8_car0_e1", cx(0), 1);
        chk("t8_car1_e1", cx(1), 6);
        chk("t8_car2_e1", cx(2), 11);
        chk("t8_car3_e1", cx(3), 16);
        chk("t8_done_e1", bus.done, 0);
        repeat (3) @(negedge clk);
        chk("t8_done_e4", bus.done, 0);
        @(negedge clk);
        chk("t8_done_e5", bus.done, 1);
        chk("t8_busy_e5", bus.busy, 0);
        chk("t8_hit_e5", bus.hit, 0);
        @(negedge clk);
        chk("t8_done_e6", bus.done, 0);
        chk("t8_car12", cx(12), 4);

        // Level 3: every lane moves each frame.
        do_reset();
        bus.level = 2'd3;
        run_frame(h, lat);
        chk("l3_f1_car4", cx(4), 1);
        chk("l3_f1_car0", cx(0), 1);
        run_frame(h, lat);
        chk("l3_f2_car4", cx(4), 0);
        run_frame(h, lat);
        chk("l3_f3_car4", cx(4), 19);
        chk("l3_f3_car0", cx(0), 3);
        chk("l3_f3_car8", cx(8), 7);
        chk("l3_f3_car12", cx(12), 3);

        // Collision: car1 steps 5 -> 6 onto the frog.
        do_reset();
        bus.level    = 2'd3;
        bus.frog_col = 5'd6;
        bus.frog_row = 4'd7;
        chk("frog_idle_hit", bus.hit, 0);
        run_frame(h, lat);
        chk("frog_hit", h, 1);
        chk("frog_hit_latency", lat, 5);
        @(negedge clk);
        chk("frog_hit_e6", bus.hit, 0);
        chk("frog_done_e6", bus.done, 0);
        do_reset();
        bus.frog_row = 4'd6;
        run_frame(h, lat);
        chk("frog_row6_hit", h, 0);
        chk("frog_row6_latency", lat, 5);

        // Pause: no motion or counting, collision still evaluated.
        do_reset();
        bus.level    = 2'd0;
        bus.pause    = 1'b1;
        bus.frog_col = 5'd0;
        bus.frog_row = 4'd7;
        hits = 0;
        for (int t = 0; t < 20; t++) begin
            run_frame(h, lat);
            if (h) hits++;
        end
        chk("pause_hits", hits, 20);
        bus.pause    = 1'b0;
        bus.frog_col = 5'd31;
        bus.frog_row = 4'd15;
        chk("pause_car0", cx(0), 0);
        chk("pause_car4", cx(4), 2);
        chk("pause_car8", cx(8), 4);
        chk("pause_car12", cx(12), 6);
        for (int t = 0; t < 3; t++) run_frame(h, lat);
        chk("unpause_3_car12", cx(12), 6);
        run_frame(h, lat);
        chk("unpause_4_car12", cx(12), 5);

        // Tick sampled at E2 while busy.
        do_reset();
        bus.level = 2'd3;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        chk("ovr_pulse", bus.overrun, 1);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        chk("ovr_clear", bus.overrun, 0);
        @(negedge clk);
        @(negedge clk);
        chk("ovr_done_e5", bus.done, 1);
        chk("ovr_car0", cx(0), 1);
        @(negedge clk);
        chk("ovr_no_requeue", bus.busy, 0);

        // Reset sampled at E3 aborts the sweep.
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        chk("abort_car0_e1", cx(0), 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_car0", cx(0), 0);
        chk("abort_busy", bus.busy, 0);
        rst = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("abort_no_done", dn, 0);
        run_frame(h, lat);
        chk("post_abort_latency", lat, 5);
        chk("post_abort_car0", cx(0), 1);

        // Reset wins over a simultaneous tick.
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        chk("rst_vs_tick_busy", bus.busy, 0);
        @(negedge clk);
        chk("rst_vs_tick_busy2", bus.busy, 0);

        // Tick sampled at E5 starts the next sweep without a gap.
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("b2b_done", bus.done, 1);
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_overrun", bus.overrun, 0);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        chk("b2b_latency", lat, 5);
        chk("b2b_car0", cx(0), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
